// File: rtl/nibbler_pkg.sv
// nibbler_pkg: constants and types shared by the nibbler sequencer slice.
//   - Opcode encodings OP_LIT .. OP_F (IR[7:4]).
//   - ALU select codes driven on alu_s.
//   - Sequencer state encodings.
//   - Jump-condition codes and the decoded control word.
// Optional feature macro: NIBBLER_HALT_EN (opcode F becomes HALT, else NOP).
package nibbler_pkg;

   localparam logic [3:0] OP_LIT   = 4'h0;
   localparam logic [3:0] OP_CMPI  = 4'h1;
   localparam logic [3:0] OP_ADDI  = 4'h2;
   localparam logic [3:0] OP_NANDI = 4'h3;
   localparam logic [3:0] OP_LD    = 4'h4;
   localparam logic [3:0] OP_ST    = 4'h5;
   localparam logic [3:0] OP_ADDM  = 4'h6;
   localparam logic [3:0] OP_CMPM  = 4'h7;
   localparam logic [3:0] OP_NANDM = 4'h8;
   localparam logic [3:0] OP_JC    = 4'h9;
   localparam logic [3:0] OP_JNC   = 4'hA;
   localparam logic [3:0] OP_JZ    = 4'hB;
   localparam logic [3:0] OP_JNZ   = 4'hC;
   localparam logic [3:0] OP_JMP   = 4'hD;
   localparam logic [3:0] OP_OUT   = 4'hE;
   localparam logic [3:0] OP_F     = 4'hF;

   localparam logic [2:0] ALU_PASS_A = 3'd0;
   localparam logic [2:0] ALU_SUB    = 3'd1;
   localparam logic [2:0] ALU_PASS_B = 3'd2;
   localparam logic [2:0] ALU_ADD    = 3'd3;
   localparam logic [2:0] ALU_NAND   = 3'd4;

   localparam logic [1:0] S_FETCH  = 2'd0;
   localparam logic [1:0] S_FETCH2 = 2'd1;
   localparam logic [1:0] S_EXEC   = 2'd2;

   localparam logic [2:0] JC_C      = 3'd0;
   localparam logic [2:0] JC_NC     = 3'd1;
   localparam logic [2:0] JC_Z      = 3'd2;
   localparam logic [2:0] JC_NZ     = 3'd3;
   localparam logic [2:0] JC_ALWAYS = 3'd4;

   typedef struct packed {
      logic       two_byte;
      logic [2:0] alu_s;
      logic       b_from_mem;
      logic       wr_acc;
      logic       upd_c;
      logic       upd_z;
      logic       is_jmp;
      logic [2:0] jcond;
      logic       is_st;
      logic       is_out;
`ifdef NIBBLER_HALT_EN
      logic       is_halt;
`endif
   } ctrl_t;

endpackage

// File: rtl/nibbler_decode.sv
// nibbler_decode: combinational opcode -> control word decoder.
// Ports:
//   opcode  in   4       instruction opcode (IR[7:4] or ROM byte [7:4])
//   ctrl    out  ctrl_t  decoded control word
// Optional feature macro: NIBBLER_HALT_EN (sets ctrl.is_halt for opcode F).
module nibbler_decode
   import nibbler_pkg::*;
(
   input  logic [3:0] opcode,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl          = '0;
      ctrl.alu_s    = ALU_PASS_A;
      ctrl.jcond    = JC_ALWAYS;
      ctrl.two_byte = (opcode >= OP_LD) && (opcode <= OP_JMP);
      case (opcode)
         OP_LIT: begin
            ctrl.alu_s  = ALU_PASS_B;
            ctrl.wr_acc = 1'b1;
            ctrl.upd_z  = 1'b1;
         end
         OP_CMPI: begin
            ctrl.alu_s = ALU_SUB;
            ctrl.upd_c = 1'b1;
            ctrl.upd_z = 1'b1;
         end
         OP_ADDI: begin
            ctrl.alu_s  = ALU_ADD;
            ctrl.wr_acc = 1'b1;
            ctrl.upd_c  = 1'b1;
            ctrl.upd_z  = 1'b1;
         end
         OP_NANDI: begin
            ctrl.alu_s  = ALU_NAND;
            ctrl.wr_acc = 1'b1;
            ctrl.upd_z  = 1'b1;
         end
         OP_LD: begin
            ctrl.alu_s      = ALU_PASS_B;
            ctrl.b_from_mem = 1'b1;
            ctrl.wr_acc     = 1'b1;
            ctrl.upd_z      = 1'b1;
         end
         OP_ST: ctrl.is_st = 1'b1;
         OP_ADDM: begin
            ctrl.alu_s      = ALU_ADD;
            ctrl.b_from_mem = 1'b1;
            ctrl.wr_acc     = 1'b1;
            ctrl.upd_c      = 1'b1;
            ctrl.upd_z      = 1'b1;
         end
         OP_CMPM: begin
            ctrl.alu_s      = ALU_SUB;
            ctrl.b_from_mem = 1'b1;
            ctrl.upd_c      = 1'b1;
            ctrl.upd_z      = 1'b1;
         end
         OP_NANDM: begin
            ctrl.alu_s      = ALU_NAND;
            ctrl.b_from_mem = 1'b1;
            ctrl.wr_acc     = 1'b1;
            ctrl.upd_z      = 1'b1;
         end
         OP_JC: begin
            ctrl.is_jmp = 1'b1;
            ctrl.jcond  = JC_C;
         end
         OP_JNC: begin
            ctrl.is_jmp = 1'b1;
            ctrl.jcond  = JC_NC;
         end
         OP_JZ: begin
            ctrl.is_jmp = 1'b1;
            ctrl.jcond  = JC_Z;
         end
         OP_JNZ: begin
            ctrl.is_jmp = 1'b1;
            ctrl.jcond  = JC_NZ;
         end
         OP_JMP: ctrl.is_jmp = 1'b1;
         OP_OUT: ctrl.is_out = 1'b1;
         OP_F: begin
`ifdef NIBBLER_HALT_EN
            ctrl.is_halt = 1'b1;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/nibbler_sequencer.sv
// nibbler_sequencer: fetch/decode/execute sequencer in front of a 4-bit ALU.
// Owns PC, IR, ACC and the C/Z flags; drives the ALU, program ROM, data RAM
// and a 4-bit output port.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   permit a new fetch (sampled in FETCH only)
//   prog_addr/prog_data   program ROM address (= PC) / combinational byte
//   data_addr/data_rdata  data RAM address {operand, addr_lo} / read nibble
//   data_wdata/data_we    RAM write data (= ACC) / write strobe (EXEC of ST)
//   alu_s/alu_a/alu_b     ALU select / A (= ACC) / B operand
//   alu_y/alu_zero/alu_cout  ALU result, zero flag, carry/borrow
//   acc_q, flag_c, flag_z ACC and registered flags
//   out_data/out_valid    output port register / one-clock pulse on OUT
//   halted                halt status
// Optional feature macro: NIBBLER_HALT_EN (opcode F = HALT; else NOP and
// halted is tied to 0).
module nibbler_sequencer
   import nibbler_pkg::*;
#(
   parameter int unsigned     PC_W     = 12,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic [PC_W-1:0] prog_addr,
   input  logic [7:0]      prog_data,
   output logic [PC_W-1:0] data_addr,
   input  logic [3:0]      data_rdata,
   output logic [3:0]      data_wdata,
   output logic            data_we,
   output logic [2:0]      alu_s,
   output logic [3:0]      alu_a,
   output logic [3:0]      alu_b,
   input  logic [3:0]      alu_y,
   input  logic            alu_zero,
   input  logic            alu_cout,
   output logic [3:0]      acc_q,
   output logic            flag_c,
   output logic            flag_z,
   output logic [3:0]      out_data,
   output logic            out_valid,
   output logic            halted
);

   logic [1:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic [7:0]      addr_lo_q, addr_lo_d;
   logic [3:0]      acc_d;
   logic            c_q, c_d;
   logic            z_q, z_d;
   logic [3:0]      out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            halt_hold;

   logic [3:0]      dec_op;
   ctrl_t           ctrl;
   logic [PC_W-1:0] target;
   logic            jump_taken;
   logic            in_exec;

`ifdef NIBBLER_HALT_EN
   logic            halted_q, halted_d;
   assign halt_hold = halted_q;
   assign halted    = halted_q;
`else
   assign halt_hold = 1'b0;
   assign halted    = 1'b0;
`endif

   // One decoder serves both phases: in FETCH it sees the incoming ROM byte
   // (to choose FETCH2 vs EXEC), afterwards it sees the latched IR.
   assign dec_op = (state_q == S_FETCH) ? prog_data[7:4] : ir_q[7:4];

   nibbler_decode u_decode (
      .opcode (dec_op),
      .ctrl   (ctrl)
   );

   assign in_exec = (state_q == S_EXEC);
   assign target  = PC_W'({ir_q[3:0], addr_lo_q});

   always_comb begin
      case (ctrl.jcond)
         JC_C:    jump_taken = c_q;
         JC_NC:   jump_taken = ~c_q;
         JC_Z:    jump_taken = z_q;
         JC_NZ:   jump_taken = ~z_q;
         default: jump_taken = 1'b1;
      endcase
   end

   assign prog_addr  = pc_q;
   assign data_addr  = target;
   assign data_wdata = acc_q;
   assign data_we    = in_exec & ctrl.is_st;
   assign alu_a      = acc_q;
   assign alu_s      = in_exec ? ctrl.alu_s : ALU_PASS_A;
   assign alu_b      = in_exec ? (ctrl.b_from_mem ? data_rdata : ir_q[3:0]) : 4'h0;
   assign flag_c     = c_q;
   assign flag_z     = z_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      addr_lo_d   = addr_lo_q;
      acc_d       = acc_q;
      c_d         = c_q;
      z_d         = z_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
`ifdef NIBBLER_HALT_EN
      halted_d    = halted_q;
`endif
      case (state_q)
         S_FETCH: begin
            if (run && !halt_hold) begin
               ir_d    = prog_data;
               pc_d    = pc_q + PC_W'(1);
               state_d = ctrl.two_byte ? S_FETCH2 : S_EXEC;
            end
         end
         S_FETCH2: begin
            addr_lo_d = prog_data;
            pc_d      = pc_q + PC_W'(1);
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            if (ctrl.wr_acc) acc_d = alu_y;
            if (ctrl.upd_c)  c_d   = alu_cout;
            if (ctrl.upd_z)  z_d   = alu_zero;
            if (ctrl.is_jmp && jump_taken) pc_d = target;
            if (ctrl.is_out) begin
               out_data_d  = acc_q;
               out_valid_d = 1'b1;
            end
`ifdef NIBBLER_HALT_EN
            if (ctrl.is_halt) halted_d = 1'b1;
`endif
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         addr_lo_q   <= '0;
         acc_q       <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         addr_lo_q   <= addr_lo_d;
         acc_q       <= acc_d;
         c_q         <= c_d;
         z_q         <= z_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef NIBBLER_HALT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) halted_q <= 1'b0;
      else        halted_q <= halted_d;
   end
`endif

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Self-checking bench for nibbler_sequencer: the bench plays ALU, ROM and RAM,
// and an instruction-level model predicts every output each cycle.
`timescale 1ns/1ps
module tb_nibbler_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;

   logic [11:0] prog_addr, data_addr;
   logic [7:0]  prog_data;
   logic [3:0]  data_rdata, data_wdata, alu_a, alu_b, alu_y, acc_q, out_data;
   logic [2:0]  alu_s;
   logic        data_we, alu_zero, alu_cout, flag_c, flag_z, out_valid, halted;

   logic [11:0] w_prog_addr, w_data_addr;
   logic [3:0]  w_data_wdata, w_alu_a, w_alu_b, w_alu_y, w_acc_q, w_out_data;
   logic [2:0]  w_alu_s;
   logic        w_data_we, w_alu_zero, w_alu_cout, w_flag_c, w_flag_z, w_out_valid, w_halted;

   logic [7:0]  rom  [0:4095];
   logic [3:0]  ram  [0:4095];
   logic [3:0]  mram [0:4095];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [5:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] r;
      case (s)
         3'd0: r = {1'b0, a};
         3'd1: r = {1'b0, a} - {1'b0, b};
         3'd2: r = {1'b0, b};
         3'd3: r = {1'b0, a} + {1'b0, b};
         3'd4: r = {1'b0, ~(a & b)};
         default: r = 5'd0;
      endcase
      return {r[4], (r[3:0] == 4'h0), r[3:0]};
   endfunction

   assign {alu_cout, alu_zero, alu_y}       = alu_f(alu_s, alu_a, alu_b);
   assign {w_alu_cout, w_alu_zero, w_alu_y} = alu_f(w_alu_s, w_alu_a, w_alu_b);
   assign prog_data  = rom[prog_addr];
   assign data_rdata = ram[data_addr];

   always @(posedge clk) if (data_we) ram[data_addr] <= data_wdata;

   nibbler_sequencer #(.PC_W(12), .RESET_PC(12'h000)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .prog_addr(prog_addr), .prog_data(prog_data),
      .data_addr(data_addr), .data_rdata(data_rdata),
      .data_wdata(data_wdata), .data_we(data_we),
      .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
      .alu_y(alu_y), .alu_zero(alu_zero), .alu_cout(alu_cout),
      .acc_q(acc_q), .flag_c(flag_c), .flag_z(flag_z),
      .out_data(out_data), .out_valid(out_valid), .halted(halted)
   );

   nibbler_sequencer #(.PC_W(12), .RESET_PC(12'hFFF)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .run(run),
      .prog_addr(w_prog_addr), .prog_data(rom[w_prog_addr]),
      .data_addr(w_data_addr), .data_rdata(4'h0),
      .data_wdata(w_data_wdata), .data_we(w_data_we),
      .alu_s(w_alu_s), .alu_a(w_alu_a), .alu_b(w_alu_b),
      .alu_y(w_alu_y), .alu_zero(w_alu_zero), .alu_cout(w_alu_cout),
      .acc_q(w_acc_q), .flag_c(w_flag_c), .flag_z(w_flag_z),
      .out_data(w_out_data), .out_valid(w_out_valid), .halted(w_halted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction-level model ----------------
   logic [11:0] m_pc;
   logic [3:0]  m_acc, m_out;
   logic        m_c, m_z, m_ov, m_halt, m_busy;
   int          m_left;
   // result of the in-flight instruction, committed when it completes
   logic [11:0] r_pc, r_waddr;
   logic [3:0]  r_acc, r_out, r_wdata;
   logic        r_c, r_z, r_ov, r_halt, r_we;
   // what the ALU/RAM ports must show during the execute cycle
   logic [2:0]  e_alu_s;
   logic [3:0]  e_b;
   logic [11:0] e_addr;
   logic        e_chk_b, e_chk_addr;

   task automatic model_reset();
      m_pc = 12'h000; m_acc = 4'h0; m_out = 4'h0;
      m_c = 1'b0; m_z = 1'b0; m_ov = 1'b0; m_halt = 1'b0;
      m_busy = 1'b0; m_left = 0; r_we = 1'b0;
   endtask

   task automatic model_start();
      logic [7:0]  ib, lo;
      logic [3:0]  op, n, a, b, mv;
      logic [11:0] t;
      logic [4:0]  s;
      logic        two;
      ib  = rom[m_pc];
      op  = ib[7:4];
      n   = ib[3:0];
      two = (op >= 4'h4) && (op <= 4'hD);
      lo  = two ? rom[m_pc + 12'd1] : 8'h00;
      t   = {n, lo};
      mv  = mram[t];
      a   = m_acc;
      b   = (op <= 4'h3) ? n : mv;
      r_pc = m_pc + (two ? 12'd2 : 12'd1);
      r_acc = m_acc; r_c = m_c; r_z = m_z; r_out = m_out; r_ov = 1'b0;
      r_halt = m_halt; r_we = 1'b0; r_waddr = t; r_wdata = a;
      e_alu_s = 3'd0; e_b = b; e_chk_b = 1'b1; e_addr = t;
      e_chk_addr = two && (op <= 4'h8);
      case (op)
         4'h0, 4'h4: begin r_acc = b; r_z = (b == 4'h0); e_alu_s = 3'd2; end
         4'h1, 4'h7: begin r_c = (a < b); r_z = (a == b); e_alu_s = 3'd1; end
         4'h2, 4'h6: begin
            s = {1'b0, a} + {1'b0, b};
            r_acc = s[3:0]; r_c = s[4]; r_z = (s[3:0] == 4'h0); e_alu_s = 3'd3;
         end
         4'h3, 4'h8: begin r_acc = ~(a & b); r_z = (r_acc == 4'h0); e_alu_s = 3'd4; end
         4'h5: begin r_we = 1'b1; e_chk_b = 1'b0; end
         4'h9: begin if (m_c)  r_pc = t; e_chk_b = 1'b0; end
         4'hA: begin if (!m_c) r_pc = t; e_chk_b = 1'b0; end
         4'hB: begin if (m_z)  r_pc = t; e_chk_b = 1'b0; end
         4'hC: begin if (!m_z) r_pc = t; e_chk_b = 1'b0; end
         4'hD: begin r_pc = t; e_chk_b = 1'b0; end
         4'hE: begin r_out = a; r_ov = 1'b1; e_chk_b = 1'b0; end
         default: begin
`ifdef NIBBLER_HALT_EN
            r_halt = 1'b1;
`endif
            e_chk_b = 1'b0;
         end
      endcase
      m_pc   = m_pc + 12'd1;
      m_busy = 1'b1;
      m_left = two ? 2 : 1;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            m_ov = 1'b0;
            if (!m_busy) begin
               if (run && !m_halt) model_start();
            end else begin
               m_left--;
               if (m_left != 0) m_pc = m_pc + 12'd1;
               else begin
                  m_pc = r_pc; m_acc = r_acc; m_c = r_c; m_z = r_z;
                  m_out = r_out; m_ov = r_ov; m_halt = r_halt;
                  if (r_we) mram[r_waddr] = r_wdata;
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic ex;
      forever begin
         @(negedge clk);
         ex = m_busy && (m_left == 1);
         check("prog_addr", 32'(prog_addr), 32'(m_pc));
         check("acc_q", 32'(acc_q), 32'(m_acc));
         check("alu_a", 32'(alu_a), 32'(m_acc));
         check("data_wdata", 32'(data_wdata), 32'(m_acc));
         check("flag_c", 32'(flag_c), 32'(m_c));
         check("flag_z", 32'(flag_z), 32'(m_z));
         check("out_data", 32'(out_data), 32'(m_out));
         check("out_valid", 32'(out_valid), 32'(m_ov));
         check("halted", 32'(halted), 32'(m_halt));
         check("data_we", 32'(data_we), 32'(ex && r_we));
         check("alu_s", 32'(alu_s), 32'(ex ? e_alu_s : 3'd0));
         if (!ex) check("alu_b_idle", 32'(alu_b), 32'h0);
         else if (e_chk_b) check("alu_b", 32'(alu_b), 32'(e_b));
         if (ex && e_chk_addr) check("data_addr", 32'(data_addr), 32'(e_addr));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // ---------------- stimulus and literal expectations ----------------
   initial begin
      int mism;
      for (int i = 0; i < 4096; i++) begin
         rom[i]  = 8'h00;
         ram[i]  = 4'($urandom_range(0, 15));
         mram[i] = ram[i];
      end
      ram[12'h0A5] = 4'h2; mram[12'h0A5] = 4'h2;
      ram[12'h0B6] = 4'h3; mram[12'h0B6] = 4'h3;
      rom[12'h000] = 8'h09; rom[12'h001] = 8'h28; rom[12'h002] = 8'h2F;
      rom[12'h003] = 8'h00; rom[12'h004] = 8'h03; rom[12'h005] = 8'h15;
      rom[12'h006] = 8'hA1; rom[12'h007] = 8'h20;
      rom[12'h008] = 8'h91; rom[12'h009] = 8'h20;
      rom[12'h120] = 8'h0A; rom[12'h121] = 8'hE0; rom[12'h122] = 8'h07;
      rom[12'h123] = 8'h50; rom[12'h124] = 8'hA5; rom[12'h125] = 8'h00;
      rom[12'h126] = 8'h40; rom[12'h127] = 8'hA5; rom[12'h128] = 8'hF0;
      rom[12'h129] = 8'hD1; rom[12'h12A] = 8'h29;
      rom[12'hFFF] = 8'h02;

      step(2);
      rst_n = 1'b1;
      check("rst_prog_addr", 32'(prog_addr), 32'h000);
      check("rst_acc", 32'(acc_q), 32'h0);
      check("rst_flags", 32'({flag_c, flag_z}), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_wrap_pc", 32'(w_prog_addr), 32'hFFF);
      step(3);
      check("run0_freeze", 32'(prog_addr), 32'h000);
      run = 1'b1;
      step(1);
      check("first_fetch", 32'(prog_addr), 32'h001);
      check("wrap_fetch", 32'(w_prog_addr), 32'h000);
      step(3);
      check("addi8_acc", 32'(acc_q), 32'h1);
      check("addi8_cz", 32'({flag_c, flag_z}), 32'h2);
      step(2);
      check("addif_acc", 32'(acc_q), 32'h0);
      check("addif_cz", 32'({flag_c, flag_z}), 32'h3);
      step(2);
      check("lit0_cz", 32'({flag_c, flag_z}), 32'h3);
      step(4);
      check("cmpi_acc", 32'(acc_q), 32'h3);
      check("cmpi_cz", 32'({flag_c, flag_z}), 32'h2);
      step(3);
      check("jnc_not_taken", 32'(prog_addr), 32'h008);
      step(3);
      check("jc_taken", 32'(prog_addr), 32'h120);
      step(4);
      check("out_data", 32'(out_data), 32'hA);
      check("out_pulse", 32'(out_valid), 32'h1);
      step(1);
      check("out_pulse_end", 32'(out_valid), 32'h0);
      step(3);
      check("st_we", 32'(data_we), 32'h1);
      check("st_addr", 32'(data_addr), 32'h0A5);
      check("st_wdata", 32'(data_wdata), 32'h7);
      step(1);
      check("st_we_end", 32'(data_we), 32'h0);
      check("st_ram", 32'(ram[12'h0A5]), 32'h7);
      step(5);
      check("ld_acc", 32'(acc_q), 32'h7);
      check("ld_z", 32'(flag_z), 32'h0);
      step(2);
`ifdef NIBBLER_HALT_EN
      check("halt_set", 32'(halted), 32'h1);
      check("halt_pc", 32'(prog_addr), 32'h129);
      step(2);
      check("halt_hold_pc", 32'(prog_addr), 32'h129);
`else
      check("nop_halted", 32'(halted), 32'h0);
      check("nop_pc", 32'(prog_addr), 32'h129);
      step(2);
      check("nop_advance_pc", 32'(prog_addr), 32'h12B);
`endif

      // reset while ST is executing: strobe drops at once, RAM untouched
      rst_n = 1'b0;
      rom[12'h000] = 8'h07; rom[12'h001] = 8'h50; rom[12'h002] = 8'hB6;
      step(1);
      rst_n = 1'b1;
      step(4);
      check("st2_we", 32'(data_we), 32'h1);
      check("st2_addr", 32'(data_addr), 32'h0B6);
      rst_n = 1'b0;
      #1;
      check("rst_drops_we", 32'(data_we), 32'h0);
      step(1);
      check("rst_ram_kept", 32'(ram[12'h0B6]), 32'h3);

      // randomized programs, run gating and asynchronous resets
      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));
      step(1);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         step(1);
         run = ($urandom_range(0, 3) != 0);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 149) == 0 || (halted && $urandom_range(0, 9) == 0))
            rst_n = 1'b0;
      end
      step(2);
      mism = 0;
      for (int i = 0; i < 4096; i++) if (ram[i] !== mram[i]) mism++;
      check("ram_contents_mismatches", 32'(mism), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
